// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Channel-index width; a minimum of one bit keeps every index port legal.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: fixed priority or round-robin from a pointer,
// with an override that restricts the candidate set to a locked channel.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  input  arb_mode_e       mode,
  input  logic            lock_en,
  input  logic [CW-1:0]   lock_ch,
  output logic [N_CH-1:0] gnt,
  output logic [CW-1:0]   gnt_idx
);

  logic          found;
  logic [CW:0]   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (lock_en) begin
      // A held packet owns the output even when its source idles.
      if (req[lock_ch]) begin
        gnt[lock_ch] = 1'b1;
        gnt_idx      = lock_ch;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (mode == ARB_RR) begin
          cand = {1'b0, ptr} + (CW+1)'(i);
          if (cand >= (CW+1)'(N_CH)) cand = cand - (CW+1)'(N_CH);
        end else begin
          cand = (CW+1)'(i);
        end
        if (!found && req[cand[CW-1:0]]) begin
          found                = 1'b1;
          gnt[cand[CW-1:0]]    = 1'b1;
          gnt_idx              = cand[CW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with selectable fixed/round-robin
// arbitration, optional packet locking and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 4,
  parameter int LOCK_PKT = 1,
  localparam int CW      = ch_w(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_rr,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH-1:0]      in_last,
  input  logic [W-1:0]         in_data [N_CH],
  output logic [N_CH-1:0]      in_ready,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [W-1:0]         out_data,
  output logic [CW-1:0]        out_ch,
  input  logic                 out_ready
);

  logic [N_CH-1:0] gnt_p0;
  logic [CW-1:0]   gnt_idx_p0;
  logic [CW-1:0]   ptr_q;
  logic [CW-1:0]   ptr_nxt_p0;
  logic            lock_q;
  logic [CW-1:0]   lock_ch_q;
  logic            load_p0;
  logic            xfer_p0;
  logic            last_p0;

  logic            vld_p1;
  logic            last_p1;
  logic [W-1:0]    data_p1;
  logic [CW-1:0]   ch_p1;

  rr_arbiter #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .mode    (arb_mode_e'(mode_rr)),
    .lock_en (lock_q),
    .lock_ch (lock_ch_q),
    .gnt     (gnt_p0),
    .gnt_idx (gnt_idx_p0)
  );

  // ---- stage p0: arbitration and input handshake ----
  assign load_p0    = ~vld_p1 | out_ready;
  assign in_ready   = load_p0 ? gnt_p0 : '0;
  assign xfer_p0    = |(in_valid & in_ready);
  assign last_p0    = (LOCK_PKT != 0) ? in_last[gnt_idx_p0] : 1'b0;
  assign ptr_nxt_p0 = (gnt_idx_p0 == CW'(N_CH-1)) ? '0 : gnt_idx_p0 + 1'b1;

  // Pointer only moves at packet boundaries so a locked packet does not skew fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer_p0) begin
      if (LOCK_PKT == 0 || last_p0) ptr_q <= ptr_nxt_p0;
      if (LOCK_PKT != 0) begin
        lock_q    <= ~last_p0;
        lock_ch_q <= gnt_idx_p0;
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      last_p1 <= last_p0;
      data_p1 <= in_data[gnt_idx_p0];
      ch_p1   <= gnt_idx_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4-channel locking instance driven by
// a reference model, plus a 3-channel instance for the non-power-of-two case.
module tb_stream_mux_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_rr;
  logic [3:0] in_valid, in_last, in_ready;
  logic [3:0] in_data [4];
  logic       out_valid, out_last, out_ready;
  logic [3:0] out_data;
  logic [1:0] out_ch;

  logic       mode3;
  logic [2:0] v3, l3, r3;
  logic [3:0] d3 [3];
  logic       ov3, ol3, ordy3;
  logic [3:0] od3;
  logic [1:0] oc3;

  int vectors = 0;
  int errs    = 0;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] data;
    logic       last;
  } beat_t;
  beat_t sbq[$];
  int    q3[$];

  int m_ptr, m_lch;
  bit m_lock, m_ov;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .W(4), .LOCK_PKT(1)) dut (
    .clk(clk), .rst(rst), .mode_rr(mode_rr),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .W(4), .LOCK_PKT(0)) dut3 (
    .clk(clk), .rst(rst), .mode_rr(mode3),
    .in_valid(v3), .in_last(l3), .in_data(d3),
    .in_ready(r3), .out_valid(ov3), .out_last(ol3),
    .out_data(od3), .out_ch(oc3), .out_ready(ordy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mdl_win(input logic [3:0] v, input logic rr);
    int c;
    if (m_lock) return v[m_lch] ? m_lch : -1;
    for (int i = 0; i < 4; i++) begin
      c = rr ? (m_ptr + i) % 4 : i;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    m_ptr = 0; m_lch = 0; m_lock = 0; m_ov = 0;
    sbq.delete();
  endtask

  // One cycle: check handshake against the model, score outputs, advance.
  task automatic step();
    int         w;
    logic       ld;
    logic [3:0] er;
    beat_t      b;
    #1;
    w  = mdl_win(in_valid, mode_rr);
    ld = !m_ov || out_ready;
    er = '0;
    if (ld && w >= 0) er[w] = 1'b1;
    check("in_ready", in_ready, er);
    check("onehot", $onehot0(in_ready), 1);
    check("out_valid", out_valid, m_ov);
    if (out_valid && out_ready) begin
      if (sbq.size() > 0) begin
        b = sbq.pop_front();
        check("out_ch", out_ch, b.ch);
        check("out_data", out_data, b.data);
        check("out_last", out_last, b.last);
      end else begin
        check("sb_depth", sbq.size(), 1);
      end
    end
    if (er != 0) begin
      b.ch = 2'(w); b.data = in_data[w]; b.last = in_last[w];
      sbq.push_back(b);
    end
    @(posedge clk);
    if (er != 0) begin
      m_ov = 1;
      if (in_last[w]) begin
        m_ptr  = (w + 1) % 4;
        m_lock = 0;
      end else begin
        m_lock = 1;
        m_lch  = w;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = '0; out_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; mode_rr = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) in_data[c] = 4'(c);
    mode3 = 1'b1; v3 = '0; l3 = '0; ordy3 = 1'b1;
    for (int c = 0; c < 3; c++) d3[c] = 4'(c + 1);
    mdl_reset();
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_last", out_last, 0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-stream: pointer advanced, then reset forces ch0 first again.
    mode_rr = 1'b1; in_valid = 4'b0011; in_last = 4'b1111; out_ready = 1'b1;
    in_data[0] = 4'h1; in_data[1] = 4'h2;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    mdl_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_gnt", in_ready, 4'b0001);
    step(); step();
    drain();

    // Fixed priority: ch1 always beats ch3.
    mode_rr = 1'b0; in_valid = 4'b1010; in_data[3] = 4'hF;
    in_data[1] = 4'hA; step();
    in_data[1] = 4'hB; step();
    in_data[1] = 4'hC; step();
    drain();

    // Round-robin over all four channels.
    mode_rr = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int c = 0; c < 4; c++) in_data[c] = 4'(8 + c);
    for (int k = 0; k < 8; k++) step();
    drain();

    // Backpressure: held beat stays stable, then no bubble on release.
    mode_rr = 1'b0; in_valid = 4'b0001; in_data[0] = 4'h5; step();
    in_data[0] = 4'h6; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_data", out_data, 4'h5);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1; step();
    check("bp_next", out_data, 4'h6);
    drain();

    // Packet lock: ch2 keeps the grant across a valid gap; ch0 waits.
    mode_rr = 1'b1; in_data[0] = 4'h3; in_last = 4'b0001;
    in_valid = 4'b0100; in_data[2] = 4'hD; step();
    in_valid = 4'b0101; in_data[2] = 4'hE; step();
    in_valid = 4'b0001; #1; check("lock_gap", in_ready, 4'b0000); step();
    in_valid = 4'b0101; in_last = 4'b0101; in_data[2] = 4'h7; step();
    in_valid = 4'b0001; step();
    drain();

    // Three channels, round-robin: 0,1,2,0 and no index 3.
    for (int k = 0; k < 4; k++) q3.push_back(k % 3);
    check("n3_idle", ov3, 0);
    v3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      int e;
      @(posedge clk); #1;
      e = q3.pop_front();
      check("n3_valid", ov3, 1);
      check("n3_ch", oc3, e);
      check("n3_data", od3, e + 1);
    end
    v3 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N:1 stream multiplexer with valid/ready handshake on every input and on the output. It is the sequential successor of the combinational 2:1/4:1 muxes: instead of an external select, an internal arbiter (fixed-priority or round-robin, runtime-selectable) picks the source. The winning beat is registered into a single output stage. Optional packet locking holds a grant until the beat marked last. Sits between several producers and one shared consumer (bus, FIFO, serializer).

Parameters:
N_CH, 4, number of input channels; legal range is 2 or more, and N_CH need not be a power of two.
W, 4, data width in bits.
LOCK_PKT, 1, 1 = grant held from first beat through the beat with in_last=1; 0 = re-arbitrate every beat.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
mode_rr  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
in_valid  input  N_CH  per-channel valid.
in_last  input  N_CH  per-channel last-beat-of-packet flag; ignored when LOCK_PKT=0.
in_data  input  N_CH x W  per-channel data, unpacked array [N_CH].
in_ready  output  N_CH  per-channel ready; one-hot or zero.
out_valid  output  1  output register holds a beat.
out_last  output  1  last flag of the held beat.
out_data  output  W  held data.
out_ch  output  $clog2(N_CH)  source index of the held beat.
out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, any time, including mid-packet):
  - out_valid=0, out_last=0, out_data=0, out_ch=0.
  - Round-robin pointer is set to 0, lock is cleared, and no grant is held.
- Load enable: load = ~out_valid | out_ready.
- Arbitration (combinational, over in_valid):
  - Fixed mode: lowest-index valid channel wins.
  - RR mode: first valid channel at or above the pointer wins, wrapping N_CH-1→0.
  - While locked: the locked channel is the only candidate. Other valids are ignored even if the locked channel drops valid; in that case in_ready is all 0.
- in_ready[g] = load & (g is the winner). At most one bit is set. in_ready may depend on in_valid; no input may depend on in_ready combinationally.
- Transfer on channel g when in_valid[g] & in_ready[g]. On the next edge:
  - out_valid=1, out_data=in_data[g], out_last=in_last[g] (0 when LOCK_PKT=0), out_ch=g.
- Output handshake: out_valid & out_ready with no new transfer clears out_valid next cycle. out_data, out_last and out_ch stay stable while out_valid & ~out_ready.
- Latency: 1 cycle input→output. Throughput: 1 beat/cycle when out_ready is held high.
- Pointer: after each transfer the pointer becomes (g+1) mod N_CH. This applies in both modes, so a switch to RR stays fair.
- When LOCK_PKT=1, the pointer advances only on the transfer carrying in_last=1.
- Lock (LOCK_PKT=1):
  - Set on a transfer with in_last=0; the lock channel is g.
  - Cleared on a transfer with in_last=1.
  - A single-beat packet (first beat has last=1) never locks.
- mode_rr change takes effect at the next unlocked arbitration; an active lock is always honored.
- No valid input while load=1: in_ready=0, and out_valid clears if the consumer took the beat.

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum logic {ARB_FIXED=0, ARB_RR=1} arb_mode_e.
  - A localparam function for ch_idx width ($clog2 with a minimum of 1).
- Sub-module rr_arbiter:
  - Parametrised by N_CH.
  - Inputs: req, pointer, mode, lock_en, lock_ch.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- The top module holds the pointer, lock state and output register.

Test Plan:
- Reset mid-stream: in_valid=4'b0011, out_ready=1; assert rst for 1 cycle mid-traffic → out_valid=0, out_data=0 while in reset; the first grant after release goes to ch0, confirming pointer=0.
- Fixed priority: mode_rr=0, in_valid=4'b1010 held, out_ready=1 → every beat has out_ch=1; ch3 is starved; data matches ch1's words 4'hA, 4'hB, 4'hC in order at 1 beat/cycle.
- Round-robin: mode_rr=1, in_valid=4'b1111 held, all in_last=1 → out_ch sequence 0,1,2,3,0,1,...; in_ready is one-hot every cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=4'h5 → output stable, in_ready=0; out_ready=1 → next beat loads the same cycle with no bubble.
- Packet lock: LOCK_PKT=1, RR mode; ch2 sends 3 beats (last on the 3rd) while ch0 stays valid → outputs ch2,ch2,ch2, then ch0; a gap in ch2's valid mid-packet gives in_ready=0 and ch0 is not served.
- Non-power-of-two: N_CH=3, RR mode, all valid → out_ch sequence 0,1,2,0; the pointer never reaches 3.
